bcd_to_bin_seq: RTL and testbench

- Sequential converter from packed multi-digit BCD to unsigned binary, using reverse double-dabble: shift right, then subtract 3 from each digit that is >= 8.
- Consumes the BCD results produced by the team's BCD add/subtract datapath and returns them to the binary domain.
- One iteration per clock, with valid/ready handshakes on input and output.

---
 rtl/bcd_pkg.sv | 38 +++
 rtl/bcd_digit_adj.sv | 23 ++
 rtl/bcd_to_bin_seq.sv | 147 ++++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Types and constants shared by the BCD datapath blocks (BCD add/subtract
// path and the BCD-to-binary converter).
//   DIGIT_W    : width of one packed BCD digit
//   MAX_DIGIT  : largest legal BCD digit value
//   state_e    : converter FSM states
//   bin_width  : number of binary bits needed to hold 10**digits - 1
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // ceil(log2(10**digits)); evaluated at elaboration time.
    function automatic int bin_width(input int digits);
        longint unsigned pow10;
        int w;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        w = 0;
        for (int b = 0; b < 64; b++) begin
            if ((longint'(1) << w) < pow10) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// One-digit correction step of reverse double-dabble: after the right shift
// a digit that reads >= 8 carried a half-ten (5) in from the digit above as
// an 8, so 3 is taken off to turn that 8 back into a 5.
//   d_i : shifted 4-bit digit
//   d_o : corrected 4-bit digit (4-bit arithmetic, no borrow out)
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_i,
    output logic [DIGIT_W-1:0] d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd8) begin
            d_o = d_i - 4'd3;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential packed-BCD to unsigned-binary converter (reverse double-dabble,
// one bit per clock).
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   bcd_in is valid
//   in_ready   converter can accept (high only in IDLE, decoded from state)
//   bcd_in     packed BCD, digit 0 in [3:0]
//   out_valid  bin_out / err are valid
//   out_ready  downstream accepts the result
//   bin_out    binary result (0 when err is set)
//   err        at least one input digit was > 9
//   dbg_state  current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data stable until that edge; the
// result side holds out_valid/bin_out/err stable while out_ready is low.
// ---------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      err,
    output state_e                    dbg_state
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [BIN_W-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               out_valid_q;
    logic [BIN_W-1:0]   bin_out_q;
    logic               err_out_q;

    logic [BCD_W-1:0]   bcd_shr;
    logic [BCD_W-1:0]   bcd_d;
    logic [BIN_W-1:0]   bin_d;
    logic               err_d;

    // -----------------------------------------------------------------------
    // One iteration: {bcd,bin} >> 1, then per-digit correction.
    // -----------------------------------------------------------------------
    assign bcd_shr = bcd_q >> 1;
    assign bin_d   = {bcd_q[0], bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (bcd_shr[g*DIGIT_W +: DIGIT_W]),
            .d_o (bcd_d[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Any illegal digit on the incoming word.
    always_comb begin
        err_d = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                err_d = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered result outputs.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            bin_out_q   <= '0;
            err_out_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q   <= bcd_in;
                        bin_q   <= '0;
                        cnt_q   <= CNT_W'(BIN_W);
                        err_q   <= err_d;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        // Final shift lands in the output register directly so
                        // out_valid rises on the same edge as the last shift.
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        bin_out_q   <= err_q ? '0 : bin_d;
                        err_out_q   <= err_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign bin_out   = bin_out_q;
    assign err       = err_out_q;
    assign dbg_state = state_q;

`ifndef SYNTHESIS
    // A legal BCD word is fully drained into bin after BIN_W iterations.
    always @(posedge clk) begin
        if (!rst && state_q == CONV && cnt_q == CNT_W'(1) && !err_q) begin
            assert (bcd_d == '0);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_seq
// Directed and randomized checks of the BCD-to-binary converter against a
// decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_seq;
    import bcd_pkg::*;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;
    localparam int LAT    = 14;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              err;
    state_e            dbg_state;

    int n_cmp;
    int n_fail;

    // {err, bin} expected per accepted input
    logic [BIN_W:0] exp_q[$];

    bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [BIN_W:0] ref_model(input logic [15:0] b);
        int val;
        int pw;
        int d;
        logic bad;
        val = 0;
        pw  = 1;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            d   = int'(b[i*4 +: 4]);
            if (d > 9) bad = 1'b1;
            val = val + d * pw;
            pw  = pw * 10;
        end
        if (bad) return {1'b1, {BIN_W{1'b0}}};
        return {1'b0, BIN_W'(val)};
    endfunction

    // ---------------- check helper ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present one word and let it be accepted on the next rising edge.
    task automatic send(input logic [15:0] v);
        @(negedge clk);
        check("in_ready_before_send", int'(in_ready), 1);
        in_valid = 1'b1;
        bcd_in   = v;
        exp_q.push_back(ref_model(v));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count edges after the accept edge until out_valid is seen (#1 after edge).
    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
            if (lat < LAT) begin
                check("in_ready_in_conv", int'(in_ready), 0);
            end
        end
        if (!out_valid) begin
            check("timeout_out_valid", 0, 1);
        end
    endtask

    // Compare presented result with the head of the expected queue.
    task automatic score(input string tag);
        logic [BIN_W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_out"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_bin"}, int'(bin_out), int'(e[BIN_W-1:0]));
            check({tag, "_err"}, int'(err), int'(e[BIN_W]));
        end
    endtask

    task automatic convert(input string tag, input logic [15:0] v);
        int lat;
        out_ready = 1'b1;
        send(v);
        wait_out(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_in_ready_done"}, int'(in_ready), 0);
        score(tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_fall"}, int'(out_valid), 0);
        check({tag, "_back_idle"}, int'(in_ready), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [BIN_W-1:0] held;
        logic [15:0] r;

        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_bin_out", int'(bin_out), 0);
        check("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Directed cases
        convert("max9999", 16'h9999);
        convert("ten", 16'h0010);
        convert("zero", 16'h0000);
        convert("bad12A4", 16'h12A4);
        convert("after_err_0042", 16'h0042);

        // Backpressure: result held for 5 cycles
        out_ready = 1'b0;
        send(16'h0507);
        wait_out(lat);
        check("hold_latency", lat, LAT);
        held = bin_out;
        check("hold_bin_first", int'(held), 507);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(out_valid), 1);
            check("hold_bin_stable", int'(bin_out), int'(held));
            check("hold_in_ready", int'(in_ready), 0);
        end
        score("hold0507");
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", int'(out_valid), 0);
        check("hold_release_ready", int'(in_ready), 1);

        // in_valid kept high with churning data during CONV
        send(16'h0123);
        in_valid = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            bcd_in = 16'($urandom_range(0, 16'hFFFF));
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        check("ignore_latency", lat, LAT);
        score("ignore0123");
        @(posedge clk);
        #1;
        check("ignore_back_idle", int'(in_ready), 1);
        check("ignore_no_extra", int'(out_valid), 0);

        // Reset in the middle of a conversion
        send(16'h0345);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        void'(exp_q.pop_front());
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_bin_out", int'(bin_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_rel", int'(in_ready), 1);
        check("midrst_out_valid_rel", int'(out_valid), 0);
        convert("after_rst_0001", 16'h0001);

        // Randomized conversions with random backpressure
        for (int n = 0; n < 24; n++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 7) == 0) r[d*4 +: 4] = 4'($urandom_range(10, 15));
                else                           r[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            out_ready = 1'b0;
            send(r);
            wait_out(lat);
            check("rand_latency", lat, LAT);
            score("rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("rand_still_valid", int'(out_valid), 1);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("rand_valid_fall", int'(out_valid), 0);
        end

        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
